// File: rtl/jp_pkg.sv
// jp_pkg: scanner state encoding, button indices, CPU register addresses and
// the counter-width helper shared by the NES joypad controller.
package jp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LATCH  = 3'd1,
    ST_SAMPLE = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_CLK_HI = 3'd4,
    ST_DONE   = 3'd5
  } scan_state_t;

  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

  localparam logic [15:0] JP1_ADDR = 16'h4016;
  localparam logic [15:0] JP2_ADDR = 16'h4017;

  // Width of a dwell counter that must hold the longest state duration.
  function automatic int cnt_width(input int poll_period, input int clk_div);
    int span;
    span = (poll_period > 2 * clk_div) ? poll_period : 2 * clk_div;
    return (span < 2) ? 1 : $clog2(span + 1);
  endfunction

endpackage

// File: rtl/jp_scan.sv
// jp_scan: periodic serial scanner for both NES pads; generates jp_latch/jp_clk,
// captures the 8 button bits LSB first and commits them atomically on DONE.
// Pad 2 capture exists only when JP_PAD2_EN is defined.
module jp_scan
  import jp_pkg::*;
#(
  parameter int CLK_DIV     = 600,
  parameter int POLL_PERIOD = 1666666
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data1,
  input  logic       data2,
  output logic [7:0] pad1,
  output logic [7:0] pad2,
  output logic       scan_done,
  output logic       jp_clk,
  output logic       jp_latch
);

  localparam int CW = cnt_width(POLL_PERIOD, CLK_DIV);
  localparam logic [CW-1:0] POLL_LAST  = CW'(POLL_PERIOD - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] DIV_LAST   = CW'(CLK_DIV - 1);

  scan_state_t   state_r;
  scan_state_t   next_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    bit_r;
  logic [7:0]    cap1_r;
  logic [7:0]    pad1_r;
  logic          sample_end_s;
  logic          latch_s;
  logic          clk_s;
  logic          done_s;
  logic          jp_clk_r;
  logic          jp_latch_r;
  logic          done_r;

  assign sample_end_s = (state_r == ST_SAMPLE) && (cnt_r == DIV_LAST);

  // State register, dwell counter, bit index, pad-1 capture and snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= {CW{1'b0}};
      bit_r      <= 3'd0;
      cap1_r     <= 8'h00;
      pad1_r     <= 8'h00;
      jp_clk_r   <= 1'b1;
      jp_latch_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= next_s;
      if (next_s != state_r) cnt_r <= {CW{1'b0}};
      else                   cnt_r <= cnt_r + CW'(1);
      if (state_r == ST_LATCH)
        bit_r <= 3'd0;
      else if ((state_r == ST_CLK_HI) && (next_s == ST_SAMPLE))
        bit_r <= bit_r + 3'd1;
      if (sample_end_s)
        cap1_r[bit_r] <= ~data1;
      if (state_r == ST_DONE)
        pad1_r <= cap1_r;
      jp_clk_r   <= clk_s;
      jp_latch_r <= latch_s;
      done_r     <= done_s;
    end
  end

  // Next-state logic: each state dwells until its counter reaches the limit.
  always_comb begin
    next_s = state_r;
    case (state_r)
      ST_IDLE:   if (cnt_r == POLL_LAST)  next_s = ST_LATCH;  else next_s = ST_IDLE;
      ST_LATCH:  if (cnt_r == LATCH_LAST) next_s = ST_SAMPLE; else next_s = ST_LATCH;
      ST_SAMPLE: if (cnt_r == DIV_LAST)   next_s = ST_CLK_LO; else next_s = ST_SAMPLE;
      ST_CLK_LO: if (cnt_r == DIV_LAST)   next_s = ST_CLK_HI; else next_s = ST_CLK_LO;
      ST_CLK_HI: begin
        if (cnt_r == DIV_LAST) next_s = (bit_r == 3'd7) ? ST_DONE : ST_SAMPLE;
        else                   next_s = ST_CLK_HI;
      end
      ST_DONE:   next_s = ST_IDLE;
      default:   next_s = ST_IDLE;
    endcase
  end

  // Pin values decoded from the upcoming state so they are registered in step with it.
  always_comb begin
    latch_s = 1'b0;
    clk_s   = 1'b1;
    done_s  = 1'b0;
    case (next_s)
      ST_LATCH:  latch_s = 1'b1;
      ST_CLK_LO: clk_s   = 1'b0;
      ST_DONE:   done_s  = 1'b1;
      default: begin
        latch_s = 1'b0;
        clk_s   = 1'b1;
        done_s  = 1'b0;
      end
    endcase
  end

  assign pad1      = pad1_r;
  assign scan_done = done_r;
  assign jp_clk    = jp_clk_r;
  assign jp_latch  = jp_latch_r;

`ifdef JP_PAD2_EN
  logic [7:0] cap2_r;
  logic [7:0] pad2_r;

  // Pad-2 capture and snapshot, sharing the pad-1 timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      cap2_r <= 8'h00;
      pad2_r <= 8'h00;
    end else begin
      if (sample_end_s)
        cap2_r[bit_r] <= ~data2;
      if (state_r == ST_DONE)
        pad2_r <= cap2_r;
    end
  end

  assign pad2 = pad2_r;
`else
  logic unused_data2;
  assign unused_data2 = data2;
  assign pad2 = 8'h00;
`endif

endmodule

// File: rtl/jp_ctrl.sv
// jp_ctrl: NES joypad controller top; scanner plus the CPU $4016/$4017 strobe and
// shift registers, driving an OR-bus read mux. JP_PAD2_EN enables the pad-2 path.
module jp_ctrl
  import jp_pkg::*;
#(
  parameter int CLK_DIV     = 600,
  parameter int POLL_PERIOD = 1666666
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [15:0] a_in,
  input  logic [7:0]  d_in,
  input  logic        r_nw_in,
  input  logic        jp_data1_in,
  input  logic        jp_data2_in,
  output logic [7:0]  d_out,
  output logic        jp_clk,
  output logic        jp_latch
);

  logic [7:0] pad1_s;
  logic [7:0] pad2_s;
  logic       scan_done_s;
  logic       sel1_s;
  logic       wr1_s;
  logic       pop1_s;
  logic       sel1_q_r;
  logic       strobe_r;
  logic [7:0] sh1_r;

  jp_scan #(
    .CLK_DIV     (CLK_DIV),
    .POLL_PERIOD (POLL_PERIOD)
  ) u_scan (
    .clk       (clk_in),
    .rst       (rst_in),
    .data1     (jp_data1_in),
    .data2     (jp_data2_in),
    .pad1      (pad1_s),
    .pad2      (pad2_s),
    .scan_done (scan_done_s),
    .jp_clk    (jp_clk),
    .jp_latch  (jp_latch)
  );

  assign sel1_s = r_nw_in && (a_in == JP1_ADDR);
  assign wr1_s  = !r_nw_in && (a_in == JP1_ADDR);
  // A read completes on the first cycle its select is low again.
  assign pop1_s = sel1_q_r && !sel1_s;

  // Strobe latch and pad-1 shift register; strobe reload beats a write, a write beats a shift.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      strobe_r <= 1'b0;
      sel1_q_r <= 1'b0;
      sh1_r    <= 8'h00;
    end else begin
      if (wr1_s) strobe_r <= d_in[0];
      sel1_q_r <= sel1_s;
      if (strobe_r)
        sh1_r <= pad1_s;
      else if (pop1_s && !wr1_s)
        sh1_r <= {1'b1, sh1_r[7:1]};
    end
  end

`ifdef JP_PAD2_EN
  logic       sel2_s;
  logic       pop2_s;
  logic       sel2_q_r;
  logic [7:0] sh2_r;

  assign sel2_s = r_nw_in && (a_in == JP2_ADDR);
  assign pop2_s = sel2_q_r && !sel2_s;

  // Pad-2 shift register, same rules as pad 1.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sel2_q_r <= 1'b0;
      sh2_r    <= 8'h00;
    end else begin
      sel2_q_r <= sel2_s;
      if (strobe_r)
        sh2_r <= pad2_s;
      else if (pop2_s && !wr1_s)
        sh2_r <= {1'b1, sh2_r[7:1]};
    end
  end

  logic unused_bits;
  assign unused_bits = ^{d_in[7:1], scan_done_s};
`else
  logic unused_bits;
  assign unused_bits = ^{d_in[7:1], scan_done_s, pad2_s};
`endif

  // CPU read mux: drives zero unless one of the pad registers is being read.
  always_comb begin
    d_out = 8'h00;
    if (sel1_s)
      d_out = {7'b0000000, sh1_r[0]};
`ifdef JP_PAD2_EN
    else if (sel2_s)
      d_out = {7'b0000000, sh2_r[0]};
`endif
    else
      d_out = 8'h00;
  end

endmodule

// File: tb/tb_jp_ctrl.sv
// tb_jp_ctrl: directed bench for jp_ctrl with a serial pad model, a cycle-position
// model of the scan pins and a commit model of the pad snapshots.
`timescale 1ns/1ps
module tb_jp_ctrl;

  localparam int CLK_DIV  = 4;
  localparam int POLL     = 200;
  localparam int SCAN_LEN = 26 * CLK_DIV + 1;
  localparam int PERIOD   = POLL + SCAN_LEN;

  logic        clk = 1'b0;
  logic        rst_in = 1'b1;
  logic [15:0] a_in = 16'h0000;
  logic [7:0]  d_in = 8'h00;
  logic        r_nw_in = 1'b1;
  logic        jp_data1_in;
  logic        jp_data2_in;
  logic [7:0]  d_out;
  logic        jp_clk;
  logic        jp_latch;

  jp_ctrl #(.CLK_DIV(CLK_DIV), .POLL_PERIOD(POLL)) dut (
    .clk_in      (clk),
    .rst_in      (rst_in),
    .a_in        (a_in),
    .d_in        (d_in),
    .r_nw_in     (r_nw_in),
    .jp_data1_in (jp_data1_in),
    .jp_data2_in (jp_data2_in),
    .d_out       (d_out),
    .jp_clk      (jp_clk),
    .jp_latch    (jp_latch)
  );

  always #5 clk = ~clk;

  // Serial pad model: latch selects A, each rising jp_clk advances one button.
  logic [7:0] btn1 = 8'h01;
  logic [7:0] btn2 = 8'h80;
  int         idx = 0;
  logic       prev_clk = 1'b1;
  always @(posedge clk) begin
    if (jp_latch === 1'b1) idx <= 0;
    else if (jp_clk === 1'b1 && prev_clk === 1'b0) idx <= idx + 1;
    prev_clk <= jp_clk;
  end
  assign jp_data1_in = (idx < 8) ? ~btn1[idx[2:0]] : 1'b0;
  assign jp_data2_in = (idx < 8) ? ~btn2[idx[2:0]] : 1'b0;

  // Cycle count since reset release and the committed pad snapshots.
  int         r = 0;
  logic [7:0] exp_pad1 = 8'h00;
  logic [7:0] exp_pad2 = 8'h00;
  always @(posedge clk) begin
    if (rst_in) begin
      r <= 0;
      exp_pad1 <= 8'h00;
      exp_pad2 <= 8'h00;
    end else begin
      r <= r + 1;
      if (r % PERIOD == PERIOD - 1) begin
        exp_pad1 <= btn1;
        exp_pad2 <= btn2;
      end
    end
  end

  // Expected {jp_clk, jp_latch} from the position inside the scan period.
  function automatic logic [1:0] exp_pins(input int rr);
    int ph;
    int u;
    ph = rr % PERIOD;
    if (ph < POLL) return 2'b10;
    if (ph < POLL + 2 * CLK_DIV) return 2'b11;
    if (ph >= PERIOD - 1) return 2'b10;
    u = (ph - POLL - 2 * CLK_DIV) % (3 * CLK_DIV);
    if (u >= CLK_DIV && u < 2 * CLK_DIV) return 2'b00;
    return 2'b10;
  endfunction

  function automatic logic pad_read(input logic [15:0] a, input logic rnw);
`ifdef JP_PAD2_EN
    return rnw && (a == 16'h4016 || a == 16'h4017);
`else
    return rnw && (a == 16'h4016);
`endif
  endfunction

  logic       armed = 1'b0;
  logic       req_on = 1'b0;
  int         req_kind = 0;
  logic [7:0] req_want = 8'h00;
  string      req_name = "";
  int         total = 0;
  int         bad = 0;

  // Single compare process: scan pins and idle bus every cycle, plus directed requests.
  always @(negedge clk) begin
    logic [7:0] got;
    if (armed) begin
      total++;
      if ({jp_clk, jp_latch} !== exp_pins(r)) begin
        bad++;
        $display("FAIL scan_pins r=%0d got=%b want=%b", r, {jp_clk, jp_latch}, exp_pins(r));
      end
      if (!pad_read(a_in, r_nw_in)) begin
        total++;
        if (d_out !== 8'h00) begin
          bad++;
          $display("FAIL d_out_idle r=%0d a=%h got=%h want=00", r, a_in, d_out);
        end
      end
      if (req_on) begin
        total++;
        case (req_kind)
          0:       got = d_out;
          1:       got = {6'b000000, jp_clk, jp_latch};
          default: got = 8'hFF;
        endcase
        if (got !== req_want) begin
          bad++;
          $display("FAIL %s r=%0d got=%h want=%h", req_name, r, got, req_want);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [7:0] want, input string name);
    req_kind = kind;
    req_want = want;
    req_name = name;
    req_on   = 1'b1;
    @(negedge clk);
    #1 req_on = 1'b0;
  endtask

  task automatic wait_r(input int target);
    int n = 0;
    while (r != target && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (r != target) expect_val(2, 8'h00, "wait_timeout");
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while ((r % PERIOD) != p && n < PERIOD + 4) begin
      @(posedge clk);
      #1;
      n++;
    end
    if ((r % PERIOD) != p) expect_val(2, 8'h00, "phase_timeout");
  endtask

  task automatic pins_at(input int target, input logic [1:0] want, input string name);
    wait_r(target);
    expect_val(1, {6'b000000, want}, name);
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [7:0] val);
    @(posedge clk);
    #1 a_in = addr; r_nw_in = 1'b0; d_in = val;
    @(posedge clk);
    #1 a_in = 16'h0000; r_nw_in = 1'b1; d_in = 8'h00;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic want, input string name);
    @(posedge clk);
    #1 a_in = addr; r_nw_in = 1'b1;
    expect_val(0, {7'b0000000, want}, name);
    @(posedge clk);
    #1 a_in = 16'h0000;
  endtask

  function automatic logic nth(input logic [7:0] pad, input int i);
    return (i < 8) ? pad[i] : 1'b1;
  endfunction

  initial begin
    logic [9:0] seq1;
    seq1 = 10'b11_0000_0001;
    repeat (2) @(posedge clk);
    #1 rst_in = 1'b0;
    armed = 1'b1;

    // First scan after release, pinned by hand.
    pins_at(199, 2'b10, "pre_latch");
    pins_at(200, 2'b11, "latch_rise");
    pins_at(207, 2'b11, "latch_last");
    pins_at(208, 2'b10, "sample0");
    pins_at(212, 2'b00, "clk_lo0");
    pins_at(216, 2'b10, "clk_hi0");
    pins_at(296, 2'b00, "clk_lo7");
    pins_at(304, 2'b10, "done");

    // A pressed: reads 1,0,...,0 then ones after the eighth.
    wait_r(306);
    do_write(16'h4016, 8'h01);
    do_write(16'h4016, 8'h00);
    for (int i = 0; i < 10; i++) do_read(16'h4016, seq1[i], "jp1_seq");

    do_write(16'h4016, 8'h01);
    do_write(16'h4016, 8'h00);
    for (int i = 0; i < 9; i++) begin
`ifdef JP_PAD2_EN
      do_read(16'h4017, nth(exp_pad2, i), "jp2_seq");
`else
      do_read(16'h4017, 1'b0, "jp2_absent");
`endif
    end

    // Strobe held high: reads follow the current A state and never shift.
    do_write(16'h4016, 8'h01);
    do_read(16'h4016, 1'b1, "strobe_a1");
    do_read(16'h4016, 1'b1, "strobe_a1_again");
    btn1 = 8'h34;
    wait_phase(5);
    for (int i = 0; i < 3; i++) do_read(16'h4016, 1'b0, "strobe_a0");
    btn1 = 8'h35;
    wait_phase(5);
    for (int i = 0; i < 2; i++) do_read(16'h4016, exp_pad1[0], "strobe_a_back");
    do_write(16'h4016, 8'h00);

    // Foreign accesses leave the shifter alone; a write beats a coincident shift.
    do_read(16'h4016, nth(exp_pad1, 0), "shift0");
    do_read(16'h2002, 1'b0, "rd_2002");
    do_read(16'h4015, 1'b0, "rd_4015");
    do_write(16'h4017, 8'hFF);
    do_write(16'h2002, 8'h01);
    do_read(16'h4016, nth(exp_pad1, 1), "shift1_after_other");
    @(posedge clk);
    #1 a_in = 16'h4016; r_nw_in = 1'b1;
    expect_val(0, {7'b0000000, nth(exp_pad1, 2)}, "shift2");
    @(posedge clk);
    #1 r_nw_in = 1'b0; d_in = 8'h00;
    @(posedge clk);
    #1 a_in = 16'h0000; r_nw_in = 1'b1;
    do_read(16'h4016, nth(exp_pad1, 2), "write_wins");
    do_read(16'h4016, nth(exp_pad1, 3), "shift3");
    do_read(16'h4016, nth(exp_pad1, 4), "shift4");

    // Reset during CLK_LO of bit 3.
    wait_phase(248);
    @(posedge clk);
    #1 rst_in = 1'b1;
    @(posedge clk);
    #1 rst_in = 1'b0;
    expect_val(1, 8'h02, "post_reset_pins");
    do_write(16'h4016, 8'h01);
    do_read(16'h4016, 1'b0, "pad_cleared");
    do_write(16'h4016, 8'h00);
    pins_at(199, 2'b10, "rescan_pre_latch");
    pins_at(200, 2'b11, "rescan_latch");
    wait_r(306);
    do_write(16'h4016, 8'h01);
    do_write(16'h4016, 8'h00);
    do_read(16'h4016, 1'b1, "rescan_a");
    do_read(16'h4016, 1'b0, "rescan_b");
    do_read(16'h4016, 1'b1, "rescan_select");

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
